// File: rtl/cordic_pkg.sv
// Shared constants for the vectoring CORDIC: defaults, arctangent table,
// gain-compensation constant and FSM state encoding.
package cordic_pkg;

    localparam int unsigned WIDTH_DEF = 16;
    localparam int unsigned ITER_DEF  = 16;
    localparam int unsigned GUARD_DEF = 2;

    // 1/K for 16 micro-rotations, Q0.16 (0.607253).
    localparam int KINV = 39797;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ITERATE = 2'd1,
        S_SCALE   = 2'd2
    } state_t;

    // atan(2^-idx) as a binary angle, 32768 LSB = pi, rounded.
    function automatic logic [15:0] atan_lut(input int unsigned idx);
        logic [15:0] v;
        case (idx)
            0:       v = 16'd8192;
            1:       v = 16'd4836;
            2:       v = 16'd2555;
            3:       v = 16'd1297;
            4:       v = 16'd651;
            5:       v = 16'd326;
            6:       v = 16'd163;
            7:       v = 16'd81;
            8:       v = 16'd41;
            9:       v = 16'd20;
            10:      v = 16'd10;
            11:      v = 16'd5;
            12:      v = 16'd3;
            13:      v = 16'd1;
            14:      v = 16'd1;
            default: v = 16'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/cordic_vec_iter.sv
// One combinational vectoring micro-rotation: steers y toward zero and
// accumulates the rotated angle in z.
module cordic_vec_iter
    import cordic_pkg::*;
#(
    parameter int unsigned XW = 18,
    parameter int unsigned ZW = 16,
    parameter int unsigned IW = 4
) (
    input  logic signed [XW-1:0] i_x,
    input  logic signed [XW-1:0] i_y,
    input  logic        [ZW-1:0] i_z,
    input  logic        [IW-1:0] i_i,
    output logic signed [XW-1:0] o_x,
    output logic signed [XW-1:0] o_y,
    output logic        [ZW-1:0] o_z
);

    logic signed [XW-1:0] w_xs;
    logic signed [XW-1:0] w_ys;
    logic        [ZW-1:0] w_atan;

    assign w_xs   = i_x >>> i_i;
    assign w_ys   = i_y >>> i_i;
    // Table is in 16-bit binary-angle units.
    assign w_atan = ZW'(atan_lut(32'(i_i)));

    // Rotate against the sign of y; z wraps modulo 2^ZW by design.
    always_comb begin
        if (!i_y[XW-1]) begin
            o_x = i_x + w_ys;
            o_y = i_y - w_xs;
            o_z = i_z + w_atan;
        end else begin
            o_x = i_x - w_ys;
            o_y = i_y + w_xs;
            o_z = i_z - w_atan;
        end
    end

endmodule

// File: rtl/cordic_vectoring.sv
// Iterative vectoring CORDIC: (X, Y) -> gain-compensated magnitude and
// binary angle atan2(Y, X), one micro-rotation per clock.
module cordic_vectoring
    import cordic_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned ITER  = ITER_DEF,
    parameter int unsigned GUARD = GUARD_DEF
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] X_in,
    input  logic [WIDTH-1:0] Y_in,
    output logic             Ready,
    output logic             Valid_out,
    output logic [WIDTH-1:0] Magnitude,
    output logic [WIDTH-1:0] Angle
);

    localparam int unsigned XW = WIDTH + GUARD;
    localparam int unsigned IW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int unsigned PW = XW + 18;

    localparam logic [IW-1:0]           LAST      = IW'(ITER - 1);
    localparam logic [WIDTH-1:0]        Z_PI      = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0]        MAG_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0]    MAG_MAX_P = PW'(MAG_MAX);

    state_t r_state;
    state_t w_next;

    logic signed [XW-1:0] r_x;
    logic signed [XW-1:0] r_y;
    logic [WIDTH-1:0]     r_z;
    logic [IW-1:0]        r_i;
    logic [WIDTH-1:0]     r_mag;
    logic [WIDTH-1:0]     r_ang;
    logic                 r_valid;

    logic                 w_ready;
    logic                 w_accept;
    logic signed [XW-1:0] w_x_ext;
    logic signed [XW-1:0] w_y_ext;
    logic signed [XW-1:0] w_x_step;
    logic signed [XW-1:0] w_y_step;
    logic [WIDTH-1:0]     w_z_step;
    logic signed [PW-1:0] w_prod;
    logic signed [PW-1:0] w_m;
    logic [WIDTH-1:0]     w_mag_sat;

    assign w_x_ext  = XW'($signed(X_in));
    assign w_y_ext  = XW'($signed(Y_in));
    assign w_accept = Start && w_ready;

    cordic_vec_iter #(
        .XW (XW),
        .ZW (WIDTH),
        .IW (IW)
    ) u_iter (
        .i_x (r_x),
        .i_y (r_y),
        .i_z (r_z),
        .i_i (r_i),
        .o_x (w_x_step),
        .o_y (w_y_step),
        .o_z (w_z_step)
    );

    assign w_prod = PW'(r_x) * $signed(PW'(KINV));
    assign w_m    = w_prod >>> 16;

    // Clamp the scaled magnitude into [0, 2^(WIDTH-1)-1].
    always_comb begin
        w_mag_sat = '0;
        if (w_m[PW-1]) begin
            w_mag_sat = '0;
        end else if (w_m > MAG_MAX_P) begin
            w_mag_sat = MAG_MAX;
        end else begin
            w_mag_sat = w_m[WIDTH-1:0];
        end
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (Start) begin
                    w_next = S_ITERATE;
                end
            end
            S_ITERATE: begin
                if (r_i == LAST) begin
                    w_next = S_SCALE;
                end
            end
            S_SCALE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath: operand load with quadrant pre-rotation, iteration, scaling.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_i     <= '0;
            r_mag   <= '0;
            r_ang   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_i <= '0;
                        if (X_in[WIDTH-1]) begin
                            r_x <= -w_x_ext;
                            r_y <= -w_y_ext;
                            r_z <= Z_PI;
                        end else begin
                            r_x <= w_x_ext;
                            r_y <= w_y_ext;
                            r_z <= '0;
                        end
                    end
                end
                S_ITERATE: begin
                    r_x <= w_x_step;
                    r_y <= w_y_step;
                    r_z <= w_z_step;
                    r_i <= r_i + IW'(1);
                end
                S_SCALE: begin
                    r_mag   <= w_mag_sat;
                    r_ang   <= r_z;
                    r_valid <= 1'b1;
                end
                default: begin
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign Ready     = w_ready;
    assign Valid_out = r_valid;
    assign Magnitude = r_mag;
    assign Angle     = r_ang;

endmodule

// File: tb/tb_cordic_vectoring.sv
// Scoreboard bench for cordic_vectoring: stimulus pushes expected results,
// a monitor pops and compares on every Valid_out.
module tb_cordic_vectoring;

    localparam int WIDTH = 16;
    localparam int ITER  = 16;
    localparam int GUARD = 2;

    logic             Clk = 1'b0;
    logic             Rst;
    logic             Start;
    logic [WIDTH-1:0] X_in;
    logic [WIDTH-1:0] Y_in;
    logic             Ready;
    logic             Valid_out;
    logic [WIDTH-1:0] Magnitude;
    logic [WIDTH-1:0] Angle;

    typedef struct {
        int    mag;
        int    ang;
        int    tm;
        int    ta;
        string name;
    } exp_t;

    exp_t sb[$];
    int   checks  = 0;
    int   errors  = 0;
    int   n_valid = 0;

    cordic_vectoring #(
        .WIDTH (WIDTH),
        .ITER  (ITER),
        .GUARD (GUARD)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Start     (Start),
        .X_in      (X_in),
        .Y_in      (Y_in),
        .Ready     (Ready),
        .Valid_out (Valid_out),
        .Magnitude (Magnitude),
        .Angle     (Angle)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input int act, input int req, input int tol);
        int d;
        checks++;
        d = act - req;
        if (d < 0) d = -d;
        if (d > tol) begin
            errors++;
            $display("FAIL %s actual %0d required %0d (tol %0d)", name, act, req, tol);
        end
    endtask

    task automatic check_ang(input string name, input int act, input int req, input int tol);
        int d;
        checks++;
        d = (act - req) & 32'hFFFF;
        if (d >= 32768) d = 65536 - d;
        if (d > tol) begin
            errors++;
            $display("FAIL %s actual %0d required %0d mod 65536 (tol %0d)", name, act, req, tol);
        end
    endtask

    // Monitor: every result pulse must match the oldest pending expectation.
    always @(negedge Clk) begin
        exp_t e;
        if (Valid_out === 1'b1) begin
            n_valid++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid actual pulse required none mag %0d ang %0d",
                         $signed(Magnitude), $signed(Angle));
            end else begin
                e = sb.pop_front();
                check({e.name, "_mag"}, int'($signed(Magnitude)), e.mag, e.tm);
                check_ang({e.name, "_ang"}, int'($signed(Angle)), e.ang, e.ta);
            end
        end
    end

    task automatic wait_ready(input string name);
        int k = 0;
        while (Ready !== 1'b1 && k < 100) begin
            @(posedge Clk); #1;
            k++;
        end
        if (Ready !== 1'b1) check({name, "_ready_timeout"}, 0, 1, 0);
    endtask

    // Waits for Valid_out, returns edges elapsed; flags Ready seen high before it.
    task automatic wait_valid(output int lat, output int rdy_bad);
        lat     = 0;
        rdy_bad = 0;
        while (lat < 60) begin
            @(posedge Clk); #1;
            lat++;
            if (Valid_out === 1'b1) break;
            if (Ready !== 1'b0) rdy_bad = 1;
        end
    endtask

    task automatic run_job(input int x, input int y, input int em, input int ea,
                           input int tm, input int ta, input string name);
        int   lat;
        int   rb;
        exp_t e;
        wait_ready(name);
        e.mag = em; e.ang = ea; e.tm = tm; e.ta = ta; e.name = name;
        sb.push_back(e);
        Start = 1'b1;
        X_in  = 16'(x);
        Y_in  = 16'(y);
        @(posedge Clk); #1;
        Start = 1'b0;
        X_in  = 16'hDEAD;
        Y_in  = 16'hBEEF;
        wait_valid(lat, rb);
        check({name, "_latency"}, lat, ITER + 1, 0);
        check({name, "_ready_low"}, rb, 0, 0);
        @(posedge Clk); #1;
        check({name, "_pulse_one_cycle"}, int'(Valid_out), 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        int   rb;
        exp_t e;

        Rst   = 1'b1;
        Start = 1'b0;
        X_in  = '0;
        Y_in  = '0;
        repeat (3) @(posedge Clk);
        #1;
        check("reset_ready", int'(Ready), 1, 0);
        check("reset_valid", int'(Valid_out), 0, 0);
        check("reset_mag", int'(Magnitude), 0, 0);
        check("reset_ang", int'(Angle), 0, 0);
        Rst = 1'b0;
        @(posedge Clk); #1;

        run_job( 16384,      0, 16384,      0, 4, 2, "pos_x");
        run_job(     0,  16384, 16384,  16384, 4, 2, "pos_y");
        run_job(     0, -16384, 16384, -16384, 4, 2, "neg_y");
        run_job( 16384,  16384, 23170,   8192, 6, 2, "q1_diag");
        run_job(-16384,  16384, 23170,  24576, 6, 2, "q2_diag");
        run_job(-16384,      0, 16384, -32768, 4, 2, "neg_x");
        run_job(-32768, -32768, 32767, -24576, 0, 2, "sat_q3");

        // Start held high: second operands must wait for the next IDLE cycle.
        wait_ready("hold");
        e.mag = 23170; e.ang = 8192; e.tm = 6; e.ta = 2; e.name = "hold_first";
        sb.push_back(e);
        Start = 1'b1;
        X_in  = 16'(16384);
        Y_in  = 16'(16384);
        @(posedge Clk); #1;
        e.mag = 16384; e.ang = 16384; e.tm = 4; e.ta = 2; e.name = "hold_second";
        sb.push_back(e);
        X_in = 16'(0);
        Y_in = 16'(16384);
        wait_valid(lat, rb);
        check("hold_first_latency", lat, ITER + 1, 0);
        check("hold_first_ready_low", rb, 0, 0);
        wait_valid(lat, rb);
        check("hold_second_latency", lat, ITER + 2, 0);
        Start = 1'b0;
        @(posedge Clk); #1;

        // Abort during iteration 7: no result, outputs cleared.
        wait_ready("abort");
        Start = 1'b1;
        X_in  = 16'(16384);
        Y_in  = 16'(0);
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (7) @(posedge Clk);
        #1;
        Rst = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0;
        check("abort_ready", int'(Ready), 1, 0);
        check("abort_valid", int'(Valid_out), 0, 0);
        check("abort_mag", int'(Magnitude), 0, 0);
        check("abort_ang", int'(Angle), 0, 0);
        rb = 0;
        repeat (25) begin
            @(posedge Clk); #1;
            if (Ready !== 1'b1) rb = 1;
        end
        check("abort_stays_idle", rb, 0, 0);

        run_job(0, -16384, 16384, -16384, 4, 2, "after_abort");

        repeat (5) @(posedge Clk);
        #1;
        check("scoreboard_empty", sb.size(), 0, 0);
        check("valid_count", n_valid, 10, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
